prim_subreg_rd_resp: RTL and testbench
======================================

Name: prim_subreg_rd_resp

Overview:
- Read-side companion to the subreg write arbiter: accepts software read requests and returns register data with a valid/ready response handshake.
- Sources data from a flattened bank of internal register values, or from external (hwext) registers with a multi-cycle ack and a timeout.
- Generates the one-cycle read pulse that drives the `we` of RC-type write arbiters, so read-to-clear side effects happen exactly once per accepted read.

Parameters:
- NumRegs, 8, number of register slots.
- DW, 32, data width per register.
- IdxW, 4, request index width; must satisfy 2**IdxW >= NumRegs. Indices >= NumRegs are unmapped.
- RcMask, '0 (NumRegs bits), bit i set = slot i is read-to-clear.
- ExtMask, '0 (NumRegs bits), bit i set = slot i is external.
- TimeoutCycles, 16, maximum cycles to wait for an external ack (>= 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  read request valid.
- req_ready_o  out  1  block can accept a request.
- req_idx_i  in  IdxW  register slot to read.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_data_o  out  DW  read data.
- rsp_err_o  out  1  response error (unmapped index or external timeout).
- reg_q_i  in  NumRegs*DW  current internal register values; slot i = bits [i*DW +: DW].
- re_o  out  NumRegs  one-cycle read pulse per internal RC slot.
- ext_re_o  out  NumRegs  one-cycle read strobe per external slot.
- ext_rvalid_i  in  1  external read data valid.
- ext_rdata_i  in  DW  external read data.

Behaviour:
- FSM states: IDLE, EXT_WAIT, RSP. Reset enters IDLE.
- Reset values: req_ready_o=0 during the reset cycle, then 1 in IDLE. rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, re_o=0, ext_re_o=0, timeout counter=0.
- Only one request is outstanding at a time. req_ready_o=1 only in IDLE. Accept occurs when req_valid_i && req_ready_o.
- Accept, unmapped (req_idx_i >= NumRegs):
  - next state RSP; rsp_data_o=0, rsp_err_o=1.
  - no re_o or ext_re_o pulse.
- Accept, internal slot i (ExtMask[i]=0):
  - rsp_data_o latches reg_q_i slot i at the accept edge, i.e. the pre-clear value.
  - next state RSP, err=0.
  - Latency: accept in cycle N, rsp_valid_o=1 in cycle N+1.
  - If RcMask[i]=1, re_o[i]=1 for exactly cycle N+1, even if the response stalls.
- Accept, external slot i:
  - next state EXT_WAIT; counter cleared.
  - ext_re_o[i]=1 for exactly the first EXT_WAIT cycle.
  - Each EXT_WAIT cycle: if ext_rvalid_i=1, latch ext_rdata_i, err=0, go to RSP.
  - Otherwise the counter increments. When the counter reaches TimeoutCycles, go to RSP with data=0, err=1.
  - ext_rvalid_i is sampled in the strobe cycle itself, so the minimum latency is accept N, rsp_valid_o at N+2.
  - ext_rvalid_i arriving in the same cycle the timeout is reached takes priority: data is returned, err=0.
- ext_rvalid_i outside EXT_WAIT is ignored and causes no state change.
- RSP:
  - rsp_valid_o=1; rsp_data_o and rsp_err_o are held stable until rsp_ready_i=1.
  - On the handshake, go to IDLE and clear rsp_valid_o.
  - A new request is accepted no earlier than the cycle after the handshake.
- re_o and ext_re_o are one-hot or zero and are never asserted outside the cycles stated above.
- Reset mid-operation (EXT_WAIT or RSP): abandon the transaction, return to IDLE, drop the pending response, and issue no strobes. A late ext_rvalid_i is ignored.
- Counter width is $clog2(TimeoutCycles+1); the counter saturates and does not wrap.

Test Plan:
- Internal read: reg_q_i slot 3 = 32'hA5A5_0001, request idx 3 at cycle N, rsp_ready_i=1 -> rsp_valid_o at N+1, data 32'hA5A5_0001, err 0, re_o=0.
- RC read with stall: RcMask[2]=1, slot 2 = 32'h0000_00FF, rsp_ready_i held 0 for 4 cycles:
  - re_o[2] high for exactly one cycle (N+1);
  - data stays 32'h0000_00FF during the stall;
  - req_ready_o=0 until the cycle after the handshake.
- Unmapped: idx 12 with NumRegs=8 -> rsp at N+1, data 0, err 1, no re_o or ext_re_o pulse.
- External ack: ExtMask[5]=1, ext_rvalid_i asserted 3 cycles after ext_re_o[5] with ext_rdata_i=32'hDEAD_BEEF:
  - single-cycle ext_re_o[5];
  - response data 32'hDEAD_BEEF, err 0.
- External timeout: TimeoutCycles=16, no ack -> response data 0, err 1, after 16 EXT_WAIT cycles. A later ext_rvalid_i pulse in IDLE has no effect.
- Reset mid-EXT_WAIT: assert rst_i two cycles after accept:
  - next cycle rsp_valid_o=0, req_ready_o=1 after reset releases;
  - no response is ever emitted for the aborted read.

Source files
------------

// File: rtl/prim_subreg_rd_resp_if.sv
// prim_subreg_rd_resp_if: read request/response, register bank and external read bus
interface prim_subreg_rd_resp_if #(
  parameter int NumRegs = 8,
  parameter int DW      = 32,
  parameter int IdxW    = 4
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [IdxW-1:0]       req_idx_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DW-1:0]         rsp_data_o;
  logic                  rsp_err_o;
  logic [NumRegs*DW-1:0] reg_q_i;
  logic [NumRegs-1:0]    re_o;
  logic [NumRegs-1:0]    ext_re_o;
  logic                  ext_rvalid_i;
  logic [DW-1:0]         ext_rdata_i;
  modport slave (
    input  req_valid_i, req_idx_i, rsp_ready_i, reg_q_i, ext_rvalid_i, ext_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, re_o, ext_re_o
  );
  modport master (
    output req_valid_i, req_idx_i, rsp_ready_i, reg_q_i, ext_rvalid_i, ext_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, re_o, ext_re_o
  );
endinterface

// File: rtl/prim_subreg_rd_resp.sv
// prim_subreg_rd_resp: single-outstanding register read responder with RC pulses and hwext timeout
module prim_subreg_rd_resp #(
  parameter int                NumRegs       = 8,
  parameter int                DW            = 32,
  parameter int                IdxW          = 4,
  parameter logic [NumRegs-1:0] RcMask       = '0,
  parameter logic [NumRegs-1:0] ExtMask      = '0,
  parameter int                TimeoutCycles = 16
) (
  input logic clk_i,
  input logic rst_i,
  prim_subreg_rd_resp_if.slave bus
);
  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam logic [1:0] IDLE = 2'd0, EXT_WAIT = 2'd1, RSP = 2'd2;
  logic [1:0]         state;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [DW-1:0]      data, sel_data;
  logic               err, accept, is_ext;
  logic [NumRegs-1:0] onehot, re, ext_re;
  // out-of-range indices shift the bit out, so an all-zero onehot means unmapped
  assign onehot = NumRegs'(1) << bus.req_idx_i;
  assign is_ext = |(onehot & ExtMask);
  assign accept = bus.req_valid_i && bus.req_ready_o;
  assign cnt_nx = cnt + 1'b1;
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NumRegs; i++) sel_data = onehot[i] ? bus.reg_q_i[i*DW +: DW] : sel_data;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      data   <= '0;
      err    <= 1'b0;
      re     <= '0;
      ext_re <= '0;
    end else begin
      re     <= accept ? onehot & RcMask & ~ExtMask : '0;
      ext_re <= accept ? onehot & ExtMask : '0;
      case (state)
        IDLE: if (bus.req_valid_i) begin
          cnt   <= '0;
          data  <= is_ext ? '0 : sel_data;
          err   <= ~|onehot;
          state <= is_ext ? EXT_WAIT : RSP;
        end
        EXT_WAIT: if (bus.ext_rvalid_i) begin
          data  <= bus.ext_rdata_i;
          err   <= 1'b0;
          state <= RSP;
        end else begin
          cnt <= cnt_nx;
          if (cnt_nx == CW'(TimeoutCycles)) begin
            data  <= '0;
            err   <= 1'b1;
            state <= RSP;
          end
        end
        RSP: if (bus.rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready_o = (state == IDLE) && !rst_i;
  assign bus.rsp_valid_o = state == RSP;
  assign bus.rsp_data_o  = data;
  assign bus.rsp_err_o   = err;
  assign bus.re_o        = re;
  assign bus.ext_re_o    = ext_re;
endmodule

// File: tb/tb_prim_subreg_rd_resp.sv
// tb_prim_subreg_rd_resp: directed self-checking bench for the register read responder
module tb_prim_subreg_rd_resp;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int errs = 0;
  int chks = 0;
  prim_subreg_rd_resp_if #(.NumRegs(8), .DW(32), .IdxW(4)) bus();
  prim_subreg_rd_resp #(
    .NumRegs(8), .DW(32), .IdxW(4), .RcMask(8'b0000_0100), .ExtMask(8'b0010_0000), .TimeoutCycles(16)
  ) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick;
    tick;
    chks++; if (bus.req_ready_o !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready_o); end
    chks++; if (bus.rsp_valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", bus.rsp_valid_o); end
    chks++; if (bus.rsp_data_o !== 32'h0 || bus.rsp_err_o !== 1'b0) begin errs++; $display("FAIL reset_data: got %h/%b expected 0/0", bus.rsp_data_o, bus.rsp_err_o); end
    chks++; if (bus.re_o !== 8'h0 || bus.ext_re_o !== 8'h0) begin errs++; $display("FAIL reset_strobes: got %h/%h expected 0/0", bus.re_o, bus.ext_re_o); end
    rst_i = 1'b0;
    #1;
    chks++; if (bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL idle_ready: got %b expected 1", bus.req_ready_o); end
  endtask

  task automatic test_internal;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd3; bus.rsp_ready_i = 1'b1;
    tick;
    bus.req_valid_i = 1'b0;
    chks++; if (bus.rsp_valid_o !== 1'b1) begin errs++; $display("FAIL int_valid: got %b expected 1", bus.rsp_valid_o); end
    chks++; if (bus.rsp_data_o !== 32'hA5A5_0001) begin errs++; $display("FAIL int_data: got %h expected a5a50001", bus.rsp_data_o); end
    chks++; if (bus.rsp_err_o !== 1'b0 || bus.re_o !== 8'h0) begin errs++; $display("FAIL int_err_re: got %b/%h expected 0/00", bus.rsp_err_o, bus.re_o); end
    tick;
    chks++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL int_done: got valid %b ready %b expected 0 1", bus.rsp_valid_o, bus.req_ready_o); end
  endtask

  task automatic test_rc_stall;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd2; bus.rsp_ready_i = 1'b0;
    tick;
    bus.req_valid_i = 1'b0;
    bus.reg_q_i[2*32 +: 32] = 32'h0;
    chks++; if (bus.re_o !== 8'h04) begin errs++; $display("FAIL rc_pulse: got %h expected 04", bus.re_o); end
    chks++; if (bus.rsp_data_o !== 32'h0000_00FF) begin errs++; $display("FAIL rc_data: got %h expected 000000ff", bus.rsp_data_o); end
    for (int i = 0; i < 3; i++) begin
      tick;
      chks++; if (bus.re_o !== 8'h0) begin errs++; $display("FAIL rc_pulse_once: got %h expected 00", bus.re_o); end
      chks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h0000_00FF) begin errs++; $display("FAIL rc_hold: got %b/%h expected 1/000000ff", bus.rsp_valid_o, bus.rsp_data_o); end
      chks++; if (bus.req_ready_o !== 1'b0) begin errs++; $display("FAIL rc_ready_stall: got %b expected 0", bus.req_ready_o); end
    end
    bus.rsp_ready_i = 1'b1;
    tick;
    chks++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.re_o !== 8'h0) begin errs++; $display("FAIL rc_done: got valid %b ready %b re %h expected 0 1 00", bus.rsp_valid_o, bus.req_ready_o, bus.re_o); end
  endtask

  task automatic test_unmapped;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd12;
    tick;
    bus.req_valid_i = 1'b0;
    chks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1) begin errs++; $display("FAIL unm_err: got valid %b err %b expected 1 1", bus.rsp_valid_o, bus.rsp_err_o); end
    chks++; if (bus.rsp_data_o !== 32'h0) begin errs++; $display("FAIL unm_data: got %h expected 0", bus.rsp_data_o); end
    chks++; if (bus.re_o !== 8'h0 || bus.ext_re_o !== 8'h0) begin errs++; $display("FAIL unm_strobes: got %h/%h expected 00/00", bus.re_o, bus.ext_re_o); end
    tick;
  endtask

  task automatic test_ext_ack;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd5;
    tick;
    bus.req_valid_i = 1'b0;
    chks++; if (bus.ext_re_o !== 8'h20 || bus.re_o !== 8'h0) begin errs++; $display("FAIL ext_strobe: got %h/%h expected 20/00", bus.ext_re_o, bus.re_o); end
    for (int i = 0; i < 3; i++) begin
      chks++; if (bus.rsp_valid_o !== 1'b0) begin errs++; $display("FAIL ext_wait_valid: got %b expected 0", bus.rsp_valid_o); end
      tick;
      chks++; if (bus.ext_re_o !== 8'h0) begin errs++; $display("FAIL ext_strobe_once: got %h expected 00", bus.ext_re_o); end
    end
    bus.ext_rvalid_i = 1'b1; bus.ext_rdata_i = 32'hDEAD_BEEF;
    tick;
    bus.ext_rvalid_i = 1'b0;
    chks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'hDEAD_BEEF || bus.rsp_err_o !== 1'b0) begin errs++; $display("FAIL ext_rsp: got %b/%h/%b expected 1/deadbeef/0", bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o); end
    tick;
  endtask

  task automatic test_ext_min_latency;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd5; bus.ext_rvalid_i = 1'b1; bus.ext_rdata_i = 32'h1234_5678;
    tick;
    bus.req_valid_i = 1'b0;
    chks++; if (bus.rsp_valid_o !== 1'b0) begin errs++; $display("FAIL ext_min_n1: got %b expected 0", bus.rsp_valid_o); end
    tick;
    bus.ext_rvalid_i = 1'b0;
    chks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h1234_5678) begin errs++; $display("FAIL ext_min_n2: got %b/%h expected 1/12345678", bus.rsp_valid_o, bus.rsp_data_o); end
    tick;
  endtask

  task automatic test_ext_timeout;
    int k;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd5;
    tick;
    bus.req_valid_i = 1'b0;
    k = 0;
    while (bus.rsp_valid_o !== 1'b1 && k < 40) begin tick; k++; end
    chks++; if (k != 16) begin errs++; $display("FAIL to_latency: got %0d expected 16 cycles after strobe cycle", k); end
    chks++; if (bus.rsp_data_o !== 32'h0 || bus.rsp_err_o !== 1'b1) begin errs++; $display("FAIL to_rsp: got %h/%b expected 0/1", bus.rsp_data_o, bus.rsp_err_o); end
    tick;
    bus.ext_rvalid_i = 1'b1; bus.ext_rdata_i = 32'h5555_AAAA;
    tick;
    bus.ext_rvalid_i = 1'b0;
    tick;
    chks++; if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL idle_rvalid: got valid %b ready %b expected 0 1", bus.rsp_valid_o, bus.req_ready_o); end
  endtask

  task automatic test_ext_ack_at_timeout;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd5;
    tick;
    bus.req_valid_i = 1'b0;
    repeat (15) tick;
    chk("late_wait", {31'd0, bus.rsp_valid_o}, 32'd0);
    bus.ext_rvalid_i = 1'b1; bus.ext_rdata_i = 32'hCAFE_F00D;
    tick;
    bus.ext_rvalid_i = 1'b0;
    chk("late_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
    chk("late_data", bus.rsp_data_o, 32'hCAFE_F00D);
    chk("late_err", {31'd0, bus.rsp_err_o}, 32'd0);
    tick;
  endtask

  task automatic test_reset_mid;
    int bad;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd5;
    tick;
    bus.req_valid_i = 1'b0;
    tick;
    rst_i = 1'b1;
    tick;
    chk("rst_mid_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("rst_mid_strobes", {16'd0, bus.re_o, bus.ext_re_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, bus.req_ready_o}, 32'd1);
    bus.ext_rvalid_i = 1'b1; bus.ext_rdata_i = 32'hBAD0_BAD0;
    bad = 0;
    repeat (20) begin
      tick;
      bus.ext_rvalid_i = 1'b0;
      if (bus.rsp_valid_o !== 1'b0 || bus.ext_re_o !== 8'h0) bad++;
    end
    chk("rst_mid_no_rsp", bad, 0);
  endtask

  task automatic test_back_to_back;
    bus.req_valid_i = 1'b1; bus.req_idx_i = 4'd3; bus.rsp_ready_i = 1'b1;
    tick;
    chk("b2b_first", {31'd0, bus.rsp_valid_o, 32'd0} >> 32, 32'd1);
    chk("b2b_busy", {31'd0, bus.req_ready_o}, 32'd0);
    bus.req_idx_i = 4'd1;
    tick;
    chk("b2b_gap", {30'd0, bus.rsp_valid_o, bus.req_ready_o}, 32'd1);
    tick;
    bus.req_valid_i = 1'b0;
    chk("b2b_second", {31'd0, bus.rsp_valid_o}, 32'd1);
    chk("b2b_data", bus.rsp_data_o, 32'h1000_0001);
    tick;
    chk("b2b_done", {31'd0, bus.rsp_valid_o}, 32'd0);
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_idx_i = '0; bus.rsp_ready_i = 1'b1;
    bus.ext_rvalid_i = 1'b0; bus.ext_rdata_i = '0;
    for (int i = 0; i < 8; i++) bus.reg_q_i[i*32 +: 32] = 32'h1000_0000 + i;
    bus.reg_q_i[3*32 +: 32] = 32'hA5A5_0001;
    bus.reg_q_i[2*32 +: 32] = 32'h0000_00FF;
    test_reset;
    test_internal;
    test_rc_stall;
    test_unmapped;
    test_ext_ack;
    test_ext_min_latency;
    test_ext_timeout;
    test_ext_ack_at_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
